idli_sqi_sram_m: RTL and testbench
==================================

Name: idli_sqi_sram_m

Overview:
- Synthesisable SQI serial-SRAM responder: the memory-side end of the core's low/high SQI memory interfaces.
- Emulates the 23LC1024 sequential-mode READ/WRITE protocol in quad I/O.
- Two instances sit opposite the SQI initiator in FPGA builds and the bench.
- Runs in the core clock domain; sck acts as a per-cycle transfer qualifier.

Parameters:
ADDR_W, 10, byte-address width; array holds 2^ADDR_W bytes; address wraps at 2^ADDR_W.

Ports:
i_sram_gck  input  1  core clock; all state on posedge.
i_sram_rst_n  input  1  asynchronous active-low reset.
i_sram_sck  input  1  transfer qualifier; one nibble moves on each gck edge with sck=1 and cs=0.
i_sram_cs  input  1  chip select, active-low; high ends any transaction.
i_sram_sio  input  4 (slice_t)  nibble from initiator.
o_sram_sio  output  4 (slice_t)  read-data nibble, registered.
o_sram_sio_oe  output  1  responder is driving o_sram_sio, registered.

Behaviour:
- Clock and reset: one clock, i_sram_gck. Reset is asynchronous and active-low on i_sram_rst_n.
- Reset values: state=IDLE, o_sram_sio=0, o_sram_sio_oe=0, nibble counter=0, address=0. Reset does not clear the memory array; contents are undefined at power-up and retained across reset.
- Xfer = cs==0 && sck==1 at a gck edge. When cs==0 && sck==0, all state holds.
- cs==1 at any edge forces state=IDLE and oe=0 on that edge, from any state. Mid-transaction aborts take this path.
- Nibble order is MS nibble first for the instruction, address and data.
- States:
  - IDLE: the first xfer loads the instruction high nibble and moves to INSTR; ctr=1.
  - INSTR: the second xfer completes the 8-bit opcode. 0x03 (READ) or 0x02 (WRITE) moves to ADDR with ctr=0. Any other opcode moves to IGNORE.
  - ADDR: 6 xfers shift in the 24-bit address. Bits above ADDR_W-1 are ignored. After the 6th xfer, READ moves to DUMMY and WRITE moves to WDATA.
  - DUMMY: 2 xfers with input ignored. On the 2nd xfer: o_sram_sio <= mem[addr][7:4], oe <= 1, go to RDATA, half=0.
  - RDATA: each xfer consumes the presented nibble.
    - half=0: load mem[addr][3:0], half=1.
    - half=1: addr <= addr+1 mod 2^ADDR_W, load mem[addr+1][7:4], half=0.
    - oe stays 1 until cs goes high.
  - WDATA: xfer with half=0 stores the nibble in hold and sets half=1. Xfer with half=1 writes mem[addr] <= {hold, nibble}, addr++ (wrapping), half=0.
  - IGNORE: all xfers ignored; oe=0 and no writes until cs goes high.
- A write followed by a read of the same byte in a later transaction returns the new data. The array uses a synchronous write port.
- Read data comes from a synchronous-read array. The array is read one edge ahead (next-byte prefetch), so o_sram_sio is valid at every RDATA xfer, including back-to-back xfers with no sck gaps.
- A partial byte (high nibble only) at cs deassert is discarded, and the addressed byte is unchanged.
- Wrap-around: the address after 2^ADDR_W-1 is 0, for both read and write.
- oe is never 1 outside DUMMY->RDATA. The initiator must not drive sio while oe=1 (bench checks this).

Test Plan:
- Write/read: cs=0, WRITE 0x02, addr 0x000010, data A5 3C, cs=1. Then READ 0x03, addr 0x000010, 2 dummy nibbles, 4 xfers -> o_sram_sio = A,5,3,C; oe rises on the edge of the 2nd dummy xfer.
- Wrap (ADDR_W=10): write 11 22 at 0x0003FF. Then read 2 bytes from 0x0003FF -> 11,22. A read from 0x000000 returns 22.
- Upper address bits: write 77 at 0xFF0005, read at 0x000005 -> 7,7.
- Bad opcode: send 0x05, addr, 4 nibbles -> oe stays 0 throughout; a read of that address returns prior contents.
- Abort: WRITE to 0x20 with only high nibble 9, then cs=1 -> mem[0x20] unchanged. The next transaction starts cleanly from IDLE.
- Gaps and reset: READ with 3 sck=0 cycles between each xfer -> identical nibble sequence. Asserting rst_n=0 mid-RDATA -> oe=0 and o_sram_sio=0 immediately (asynchronously). Memory is retained: a read after reset returns the same data.

Source files
------------

// File: rtl/idli_sqi_sram_m.sv
`default_nettype none
// ============================================================================
// idli_sqi_sram_m : SQI serial-SRAM responder (23LC1024 sequential READ/WRITE,
//                   quad I/O), clocked by the core clock with sck as qualifier.
// Revision        : 1.0
// ============================================================================
module idli_sqi_sram_m #(
  parameter int ADDR_W = 10
) (
  input  logic       i_sram_gck,
  input  logic       i_sram_rst_n,
  input  logic       i_sram_sck,
  input  logic       i_sram_cs,
  input  logic [3:0] i_sram_sio,
  output logic [3:0] o_sram_sio,
  output logic       o_sram_sio_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_INSTR, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          ctr_q, ctr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                half_q, half_d;
  logic [3:0]          hold_q, hold_d;
  logic                rd_q, rd_d;
  logic [3:0]          sio_q, sio_d;
  logic                oe_q, oe_d;

  logic [7:0]          mem_q [0:(1<<ADDR_W)-1];
  logic [7:0]          rdata_q;

  logic                w_xfer;
  logic                w_we;
  logic [7:0]          w_wdata;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W+3:0]   w_addr_shift;

  assign w_xfer       = ~i_sram_cs & i_sram_sck;
  assign w_addr_shift = {addr_q, i_sram_sio};
  assign o_sram_sio    = sio_q;
  assign o_sram_sio_oe = oe_q;

  always_ff @(posedge i_sram_gck or negedge i_sram_rst_n) begin
    if (!i_sram_rst_n) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      addr_q  <= '0;
      half_q  <= 1'b0;
      hold_q  <= '0;
      rd_q    <= 1'b0;
      sio_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      addr_q  <= addr_d;
      half_q  <= half_d;
      hold_q  <= hold_d;
      rd_q    <= rd_d;
      sio_q   <= sio_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    addr_d  = addr_q;
    half_d  = half_q;
    hold_d  = hold_q;
    rd_d    = rd_q;
    sio_d   = sio_q;
    oe_d    = oe_q;
    w_we    = 1'b0;
    w_wdata = {hold_q, i_sram_sio};

    if (i_sram_cs) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else if (i_sram_sck) begin
      case (state_q)
        S_IDLE: begin
          hold_d  = i_sram_sio;
          ctr_d   = 3'd1;
          state_d = S_INSTR;
        end
        S_INSTR: begin
          ctr_d = 3'd0;
          if ({hold_q, i_sram_sio} == 8'h03) begin
            rd_d    = 1'b1;
            state_d = S_ADDR;
          end else if ({hold_q, i_sram_sio} == 8'h02) begin
            rd_d    = 1'b0;
            state_d = S_ADDR;
          end else begin
            state_d = S_IGNORE;
          end
        end
        S_ADDR: begin
          addr_d = w_addr_shift[ADDR_W-1:0];
          ctr_d  = ctr_q + 3'd1;
          if (ctr_q == 3'd5) begin
            ctr_d   = 3'd0;
            half_d  = 1'b0;
            state_d = rd_q ? S_DUMMY : S_WDATA;
          end
        end
        S_DUMMY: begin
          ctr_d = ctr_q + 3'd1;
          if (ctr_q == 3'd1) begin
            sio_d   = rdata_q[7:4];
            oe_d    = 1'b1;
            half_d  = 1'b0;
            state_d = S_RDATA;
          end
        end
        S_RDATA: begin
          if (!half_q) begin
            sio_d  = rdata_q[3:0];
            half_d = 1'b1;
          end else begin
            // rdata_q already holds the next byte, fetched on the half=0 edge
            sio_d  = rdata_q[7:4];
            addr_d = addr_q + ADDR_W'(1);
            half_d = 1'b0;
          end
        end
        S_WDATA: begin
          if (!half_q) begin
            hold_d = i_sram_sio;
            half_d = 1'b1;
          end else begin
            w_we   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
            half_d = 1'b0;
          end
        end
        S_IGNORE: begin
          oe_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Keep rdata_q tracking mem[addr], or mem[addr+1] once the low nibble is out.
    w_rd_addr = addr_d;
    if (state_q == S_RDATA && (half_q || w_xfer)) begin
      w_rd_addr = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_sram_gck) begin
    if (w_we) begin
      mem_q[addr_q] <= w_wdata;
    end
    rdata_q <= mem_q[w_rd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_sram_m.sv
`default_nettype none
// Directed bench for idli_sqi_sram_m: write/read, wrap, upper address bits,
// bad opcode, aborted write, sck gaps and asynchronous reset.
module tb_idli_sqi_sram_m;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out;
  logic       oe;

  int total = 0;
  int bad   = 0;

  idli_sqi_sram_m #(.ADDR_W(10)) dut (
    .i_sram_gck    (clk),
    .i_sram_rst_n  (rst_n),
    .i_sram_sck    (sck),
    .i_sram_cs     (cs),
    .i_sram_sio    (sio_in),
    .o_sram_sio    (sio_out),
    .o_sram_sio_oe (oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [3:0] n);
    @(negedge clk);
    cs = 1'b0; sck = 1'b1; sio_in = n;
    @(posedge clk); #1;
  endtask

  task automatic gap();
    @(negedge clk);
    cs = 1'b0; sck = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cs_hi();
    @(negedge clk);
    cs = 1'b1; sck = 1'b0; sio_in = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    xfer(b[7:4]);
    xfer(b[3:0]);
  endtask

  task automatic start(input logic [7:0] op, input logic [23:0] a);
    send_byte(op);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic wr(input logic [23:0] a, input logic [15:0] d, input int nb);
    logic [15:0] dv;
    dv = d;
    start(8'h02, a);
    for (int i = 0; i < nb; i++) send_byte(dv[8*(nb-1-i) +: 8]);
    cs_hi();
  endtask

  // Checks oe low after dummy 1, then the nibble presented before each read xfer.
  task automatic rd(input string tag, input logic [23:0] a, input logic [31:0] e,
                    input int n, input int g);
    logic [31:0] ev;
    ev = e;
    start(8'h03, a);
    xfer(4'h0);
    chk({tag, "_oe_dummy1"}, {7'd0, oe}, 8'h00);
    xfer(4'h0);
    for (int i = 0; i < n; i++) begin
      if (i != 0) repeat (g) gap();
      chk($sformatf("%s_oe%0d", tag, i), {7'd0, oe}, 8'h01);
      chk($sformatf("%s_nib%0d", tag, i), {4'h0, sio_out}, {4'h0, ev[4*(n-1-i) +: 4]});
      xfer(4'h0);
    end
    cs_hi();
    chk({tag, "_oe_after_cs"}, {7'd0, oe}, 8'h00);
  endtask

  initial begin
    #12;
    chk("reset_sio", {4'h0, sio_out}, 8'h00);
    chk("reset_oe", {7'd0, oe}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cs_hi();

    // Basic write then read
    wr(24'h000010, 16'hA53C, 2);
    rd("wr_rd", 24'h000010, 32'h0000A53C, 4, 0);

    // Address wrap at 2^10
    wr(24'h0003FF, 16'h1122, 2);
    rd("wrap", 24'h0003FF, 32'h00001122, 4, 0);
    rd("wrap0", 24'h000000, 32'h00000022, 2, 0);

    // Address bits above ADDR_W ignored
    wr(24'hFF0005, 16'h0077, 1);
    rd("upper", 24'h000005, 32'h00000077, 2, 0);

    // Unsupported opcode: responder never drives
    wr(24'h000030, 16'h005A, 1);
    start(8'h05, 24'h000030);
    for (int i = 0; i < 4; i++) begin
      xfer(4'hF);
      chk($sformatf("badop_oe%0d", i), {7'd0, oe}, 8'h00);
    end
    cs_hi();
    rd("badop_rd", 24'h000030, 32'h0000005A, 2, 0);

    // Partial byte discarded on cs deassert
    wr(24'h000020, 16'h004B, 1);
    start(8'h02, 24'h000020);
    xfer(4'h9);
    cs_hi();
    rd("abort", 24'h000020, 32'h0000004B, 2, 0);

    // sck gaps between read xfers
    rd("gaps", 24'h000010, 32'h0000A53C, 4, 3);

    // Asynchronous reset mid-read
    start(8'h03, 24'h000010);
    xfer(4'h0);
    xfer(4'h0);
    xfer(4'h0);
    chk("pre_rst_sio", {4'h0, sio_out}, 8'h05);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", {7'd0, oe}, 8'h00);
    chk("async_rst_sio", {4'h0, sio_out}, 8'h00);
    @(negedge clk);
    cs = 1'b1; sck = 1'b0;
    rst_n = 1'b1;
    cs_hi();
    rd("post_rst", 24'h000010, 32'h0000A53C, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
